// File: rtl/bnn_l2_cxu.sv
// bnn_l2_cxu: binary-neural-net XNOR-popcount CXU with a CXU-L2 stream port.
// Optional feature macro: BNN_L2_CXU_POPCNT_FUNC_EN (adds func 1 = POPCNT).
//
// Ports (top bnn_l2_cxu):
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/ready     request handshake
//   req_id/func         request tag and function id
//   req_data0/1         operand vectors a and b
//   resp_valid/ready    response handshake
//   resp_id             echoed request tag
//   resp_status         0 = OK, 1 = ERROR (unsupported function)
//   resp_data           XNOR popcount result
//
// Sub-modules in this file:
//   bnn_cxu    combinational L0 core (func, a, b) -> (status, data)
//   cvt01_cxu  L0 -> L1 adapter: valid/ready wrapped around the core
//   cvt12_cxu  L1 -> L2 adapter: CXU_LATENCY-stage pipe with global stall

module bnn_cxu #(
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_FUNC_ID_W = 10
) (
    input  logic [CXU_FUNC_ID_W-1:0] func,
    input  logic [CXU_DATA_W-1:0]    data0,
    input  logic [CXU_DATA_W-1:0]    data1,
    output logic [1:0]               status,
    output logic [CXU_DATA_W-1:0]    data
);

    localparam logic [CXU_FUNC_ID_W-1:0] FUNC_DOT = '0;
`ifdef BNN_L2_CXU_POPCNT_FUNC_EN
    localparam logic [CXU_FUNC_ID_W-1:0] FUNC_POPCNT = CXU_FUNC_ID_W'(1);
`endif

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;

    function automatic logic [CXU_DATA_W-1:0] popcnt(
        input logic [CXU_DATA_W-1:0] v
    );
        logic [CXU_DATA_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CXU_DATA_W; i++) begin
            cnt = cnt + {{(CXU_DATA_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    always_comb begin
        status = ST_OK;
        data   = '0;
        if (func == FUNC_DOT) begin
            // XNOR marks agreeing bit positions, i.e. +1 products
            data = popcnt(~(data0 ^ data1));
        end
`ifdef BNN_L2_CXU_POPCNT_FUNC_EN
        else if (func == FUNC_POPCNT) begin
            data = popcnt(data0);
        end
`endif
        else begin
            status = ST_ERR;
        end
    end

endmodule

module cvt01_cxu #(
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_FUNC_ID_W = 10
) (
    // L1 side
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CXU_FUNC_ID_W-1:0] req_func,
    input  logic [CXU_DATA_W-1:0]    req_data0,
    input  logic [CXU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [1:0]               resp_status,
    output logic [CXU_DATA_W-1:0]    resp_data,
    // L0 side
    output logic [CXU_FUNC_ID_W-1:0] l0_func,
    output logic [CXU_DATA_W-1:0]    l0_data0,
    output logic [CXU_DATA_W-1:0]    l0_data1,
    input  logic [1:0]               l0_status,
    input  logic [CXU_DATA_W-1:0]    l0_data
);

    // The core answers in the same cycle, so the handshake is pass-through.
    assign req_ready   = resp_ready;
    assign resp_valid  = req_valid;
    assign l0_func     = req_func;
    assign l0_data0    = req_data0;
    assign l0_data1    = req_data1;
    assign resp_status = l0_status;
    assign resp_data   = l0_data;

endmodule

module cvt12_cxu #(
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_FUNC_ID_W = 10,
    parameter int CXU_REQ_ID_W  = 6,
    parameter int CXU_LATENCY   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    // L2 side
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CXU_REQ_ID_W-1:0]  req_id,
    input  logic [CXU_FUNC_ID_W-1:0] req_func,
    input  logic [CXU_DATA_W-1:0]    req_data0,
    input  logic [CXU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [CXU_REQ_ID_W-1:0]  resp_id,
    output logic [1:0]               resp_status,
    output logic [CXU_DATA_W-1:0]    resp_data,
    // L1 side
    output logic                     l1_req_valid,
    input  logic                     l1_req_ready,
    output logic [CXU_FUNC_ID_W-1:0] l1_req_func,
    output logic [CXU_DATA_W-1:0]    l1_req_data0,
    output logic [CXU_DATA_W-1:0]    l1_req_data1,
    input  logic                     l1_resp_valid,
    output logic                     l1_resp_ready,
    input  logic [1:0]               l1_resp_status,
    input  logic [CXU_DATA_W-1:0]    l1_resp_data
);

    assign l1_req_valid = req_valid;
    assign l1_req_func  = req_func;
    assign l1_req_data0 = req_data0;
    assign l1_req_data1 = req_data1;
    assign req_ready    = l1_req_ready;

    generate
        if (CXU_LATENCY == 0) begin : g_comb
            // No registers: clock and reset are intentionally idle here.
            logic unused;
            assign unused = clk ^ rst;

            assign l1_resp_ready = resp_ready;
            assign resp_valid    = l1_resp_valid;
            assign resp_id       = req_id;
            assign resp_status   = l1_resp_status;
            assign resp_data     = l1_resp_data;
        end else begin : g_pipe
            localparam int N = CXU_LATENCY;

            logic [N-1:0]            vld_q, vld_d;
            logic [CXU_REQ_ID_W-1:0] id_q  [N];
            logic [CXU_REQ_ID_W-1:0] id_d  [N];
            logic [1:0]              st_q  [N];
            logic [1:0]              st_d  [N];
            logic [CXU_DATA_W-1:0]   dat_q [N];
            logic [CXU_DATA_W-1:0]   dat_d [N];
            logic                    stall;

            // A full last stage that cannot drain freezes the whole pipe;
            // otherwise every stage shifts, so drain and accept overlap.
            assign stall         = vld_q[N-1] && !resp_ready;
            assign l1_resp_ready = !stall;

            always_comb begin
                vld_d = vld_q;
                id_d  = id_q;
                st_d  = st_q;
                dat_d = dat_q;
                if (!stall) begin
                    vld_d[0] = l1_resp_valid;
                    id_d[0]  = req_id;
                    st_d[0]  = l1_resp_status;
                    dat_d[0] = l1_resp_data;
                    for (int i = 1; i < N; i++) begin
                        vld_d[i] = vld_q[i-1];
                        id_d[i]  = id_q[i-1];
                        st_d[i]  = st_q[i-1];
                        dat_d[i] = dat_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < N; i++) begin
                        id_q[i]  <= '0;
                        st_q[i]  <= '0;
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    id_q  <= id_d;
                    st_q  <= st_d;
                    dat_q <= dat_d;
                end
            end

            assign resp_valid  = vld_q[N-1];
            assign resp_id     = id_q[N-1];
            assign resp_status = st_q[N-1];
            assign resp_data   = dat_q[N-1];
        end
    endgenerate

endmodule

module bnn_l2_cxu #(
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_FUNC_ID_W = 10,
    parameter int CXU_REQ_ID_W  = 6,
    parameter int CXU_LATENCY   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CXU_REQ_ID_W-1:0]  req_id,
    input  logic [CXU_FUNC_ID_W-1:0] req_func,
    input  logic [CXU_DATA_W-1:0]    req_data0,
    input  logic [CXU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [CXU_REQ_ID_W-1:0]  resp_id,
    output logic [1:0]               resp_status,
    output logic [CXU_DATA_W-1:0]    resp_data
);

    logic                     l1_req_valid;
    logic                     l1_req_ready;
    logic [CXU_FUNC_ID_W-1:0] l1_req_func;
    logic [CXU_DATA_W-1:0]    l1_req_data0;
    logic [CXU_DATA_W-1:0]    l1_req_data1;
    logic                     l1_resp_valid;
    logic                     l1_resp_ready;
    logic [1:0]               l1_resp_status;
    logic [CXU_DATA_W-1:0]    l1_resp_data;

    logic [CXU_FUNC_ID_W-1:0] l0_func;
    logic [CXU_DATA_W-1:0]    l0_data0;
    logic [CXU_DATA_W-1:0]    l0_data1;
    logic [1:0]               l0_status;
    logic [CXU_DATA_W-1:0]    l0_data;

    cvt12_cxu #(
        .CXU_DATA_W    (CXU_DATA_W),
        .CXU_FUNC_ID_W (CXU_FUNC_ID_W),
        .CXU_REQ_ID_W  (CXU_REQ_ID_W),
        .CXU_LATENCY   (CXU_LATENCY)
    ) u_cvt12 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_id         (req_id),
        .req_func       (req_func),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_status    (resp_status),
        .resp_data      (resp_data),
        .l1_req_valid   (l1_req_valid),
        .l1_req_ready   (l1_req_ready),
        .l1_req_func    (l1_req_func),
        .l1_req_data0   (l1_req_data0),
        .l1_req_data1   (l1_req_data1),
        .l1_resp_valid  (l1_resp_valid),
        .l1_resp_ready  (l1_resp_ready),
        .l1_resp_status (l1_resp_status),
        .l1_resp_data   (l1_resp_data)
    );

    cvt01_cxu #(
        .CXU_DATA_W    (CXU_DATA_W),
        .CXU_FUNC_ID_W (CXU_FUNC_ID_W)
    ) u_cvt01 (
        .req_valid   (l1_req_valid),
        .req_ready   (l1_req_ready),
        .req_func    (l1_req_func),
        .req_data0   (l1_req_data0),
        .req_data1   (l1_req_data1),
        .resp_valid  (l1_resp_valid),
        .resp_ready  (l1_resp_ready),
        .resp_status (l1_resp_status),
        .resp_data   (l1_resp_data),
        .l0_func     (l0_func),
        .l0_data0    (l0_data0),
        .l0_data1    (l0_data1),
        .l0_status   (l0_status),
        .l0_data     (l0_data)
    );

    bnn_cxu #(
        .CXU_DATA_W    (CXU_DATA_W),
        .CXU_FUNC_ID_W (CXU_FUNC_ID_W)
    ) u_core (
        .func   (l0_func),
        .data0  (l0_data0),
        .data1  (l0_data1),
        .status (l0_status),
        .data   (l0_data)
    );

endmodule

// File: tb/tb_bnn_l2_cxu.sv
// tb_bnn_l2_cxu: self-checking bench for bnn_l2_cxu.
// Three instances: 32b/lat0, 64b/lat2, 32b/lat2 with a queue reference model.

module tb_bnn_l2_cxu;

    localparam int C_LAT = 2;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    // a: 32-bit, latency 0
    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [5:0]  a_req_id, a_resp_id;
    logic [9:0]  a_req_func;
    logic [31:0] a_req_data0, a_req_data1, a_resp_data;
    logic [1:0]  a_resp_status;

    // b: 64-bit, latency 2
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [5:0]  b_req_id, b_resp_id;
    logic [9:0]  b_req_func;
    logic [63:0] b_req_data0, b_req_data1, b_resp_data;
    logic [1:0]  b_resp_status;

    // c: 32-bit, latency 2
    logic        c_req_valid, c_req_ready, c_resp_valid, c_resp_ready;
    logic [5:0]  c_req_id, c_resp_id;
    logic [9:0]  c_req_func;
    logic [31:0] c_req_data0, c_req_data1, c_resp_data;
    logic [1:0]  c_resp_status;

    // expected in-flight responses of instance c, oldest first
    logic [5:0]  q_id  [$];
    logic [1:0]  q_st  [$];
    logic [31:0] q_dat [$];
    int          q_age [$];
    logic        c_saw_stall;

    bnn_l2_cxu #(
        .CXU_DATA_W(32), .CXU_FUNC_ID_W(10),
        .CXU_REQ_ID_W(6), .CXU_LATENCY(0)
    ) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_id(a_req_id), .req_func(a_req_func),
        .req_data0(a_req_data0), .req_data1(a_req_data1),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_id(a_resp_id), .resp_status(a_resp_status),
        .resp_data(a_resp_data)
    );

    bnn_l2_cxu #(
        .CXU_DATA_W(64), .CXU_FUNC_ID_W(10),
        .CXU_REQ_ID_W(6), .CXU_LATENCY(2)
    ) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_id(b_req_id), .req_func(b_req_func),
        .req_data0(b_req_data0), .req_data1(b_req_data1),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_id(b_resp_id), .resp_status(b_resp_status),
        .resp_data(b_resp_data)
    );

    bnn_l2_cxu #(
        .CXU_DATA_W(32), .CXU_FUNC_ID_W(10),
        .CXU_REQ_ID_W(6), .CXU_LATENCY(C_LAT)
    ) u_c (
        .clk(clk), .rst(rst),
        .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_id(c_req_id), .req_func(c_req_func),
        .req_data0(c_req_data0), .req_data1(c_req_data1),
        .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
        .resp_id(c_resp_id), .resp_status(c_resp_status),
        .resp_data(c_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {status, data} for a 32-bit unit from the function rules.
    function automatic logic [33:0] ref_c(
        input logic [9:0] f, input logic [31:0] a, input logic [31:0] b
    );
        int n;
        n = 0;
        if (f == 10'd0) begin
            for (int i = 0; i < 32; i++) if (a[i] == b[i]) n++;
            return {2'd0, 32'(n)};
        end
`ifdef BNN_L2_CXU_POPCNT_FUNC_EN
        if (f == 10'd1) begin
            for (int i = 0; i < 32; i++) if (a[i]) n++;
            return {2'd0, 32'(n)};
        end
`endif
        return {2'd1, 32'd0};
    endfunction

    // One cycle on instance c; starts and ends just after a rising edge.
    task automatic c_cycle(
        input logic v, input logic [5:0] id, input logic [9:0] f,
        input logic [31:0] a, input logic [31:0] b, input logic rr,
        output logic acc
    );
        logic vis, exp_rdy, stall;
        logic [33:0] r;
        c_req_valid  = v;
        c_req_id     = id;
        c_req_func   = f;
        c_req_data0  = a;
        c_req_data1  = b;
        c_resp_ready = rr;
        @(negedge clk);
        vis     = (q_id.size() != 0) && (q_age[0] >= C_LAT);
        exp_rdy = !(vis && !rr);
        n_checks++;
        if (c_resp_valid !== vis)
            $display("FAIL c_resp_valid: got %b want %b at %0t",
                     c_resp_valid, vis, $time);
        else n_pass++;
        n_checks++;
        if (c_req_ready !== exp_rdy)
            $display("FAIL c_req_ready: got %b want %b at %0t",
                     c_req_ready, exp_rdy, $time);
        else n_pass++;
        if (vis) begin
            n_checks++;
            if (c_resp_id !== q_id[0] || c_resp_status !== q_st[0]
                || c_resp_data !== q_dat[0])
                $display("FAIL c_resp: got id %0d st %0d d %0d want id %0d st %0d d %0d",
                         c_resp_id, c_resp_status, c_resp_data,
                         q_id[0], q_st[0], q_dat[0]);
            else n_pass++;
        end
        if (!exp_rdy) c_saw_stall = 1'b1;
        stall = vis && !rr;
        if (vis && rr) begin
            void'(q_id.pop_front());
            void'(q_st.pop_front());
            void'(q_dat.pop_front());
            void'(q_age.pop_front());
        end
        if (!stall)
            for (int i = 0; i < q_age.size(); i++) q_age[i] = q_age[i] + 1;
        acc = v && exp_rdy;
        if (acc) begin
            r = ref_c(f, a, b);
            q_id.push_back(id);
            q_st.push_back(r[33:32]);
            q_dat.push_back(r[31:0]);
            q_age.push_back(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic c_drain;
        logic acc;
        for (int i = 0; i < 40 && q_id.size() != 0; i++)
            c_cycle(1'b0, 6'd0, 10'd0, 32'd0, 32'd0, 1'b1, acc);
        n_checks++;
        if (q_id.size() != 0)
            $display("FAIL c_drain: %0d responses still missing", q_id.size());
        else n_pass++;
        repeat (3) c_cycle(1'b0, 6'd0, 10'd0, 32'd0, 32'd0, 1'b1, acc);
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== a_resp_ready)
            $display("FAIL reset_a: valid %b ready %b want 0 %b",
                     a_resp_valid, a_req_ready, a_resp_ready);
        else n_pass++;
        n_checks++;
        if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1 || b_resp_data !== 64'd0
            || b_resp_id !== 6'd0 || b_resp_status !== 2'd0)
            $display("FAIL reset_b: v %b r %b d %0d id %0d st %0d want 0 1 0 0 0",
                     b_resp_valid, b_req_ready, b_resp_data, b_resp_id, b_resp_status);
        else n_pass++;
        n_checks++;
        if (c_resp_valid !== 1'b0 || c_req_ready !== 1'b1 || c_resp_data !== 32'd0
            || c_resp_id !== 6'd0 || c_resp_status !== 2'd0)
            $display("FAIL reset_c: v %b r %b d %0d id %0d st %0d want 0 1 0 0 0",
                     c_resp_valid, c_req_ready, c_resp_data, c_resp_id, c_resp_status);
        else n_pass++;
    endtask

    task automatic test_l0_dot;
        logic [31:0] av [3];
        logic [31:0] bv [3];
        int          ev [3];
        logic [31:0] a, b;
        logic [9:0]  f;
        logic [33:0] r;
        av = '{32'hFFFF_FFFF, 32'h0, 32'h0000_FFFF};
        bv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        ev = '{32, 0, 16};
        for (int i = 0; i < 3; i++) begin
            a_req_valid = 1'b1; a_req_id = 6'(i + 1); a_req_func = 10'd0;
            a_req_data0 = av[i]; a_req_data1 = bv[i]; a_resp_ready = 1'b1;
            #1;
            n_checks++;
            if (a_resp_valid !== 1'b1 || a_req_ready !== 1'b1
                || a_resp_data !== 32'(ev[i]) || a_resp_status !== 2'd0
                || a_resp_id !== 6'(i + 1))
                $display("FAIL l0_dir%0d: v %b r %b d %0d st %0d id %0d want d %0d",
                         i, a_resp_valid, a_req_ready, a_resp_data,
                         a_resp_status, a_resp_id, ev[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = (i % 3 == 0) ? ~a : $urandom;
            case ($urandom_range(0, 3))
                0, 1: f = 10'd0;
                2: f = 10'd1;
                default: f = 10'($urandom_range(2, 1023));
            endcase
            r = ref_c(f, a, b);
            a_req_valid = 1'b1; a_req_id = 6'($urandom); a_req_func = f;
            a_req_data0 = a; a_req_data1 = b; a_resp_ready = i[0];
            #1;
            n_checks++;
            if (a_resp_valid !== 1'b1 || a_req_ready !== i[0]
                || a_resp_status !== r[33:32] || a_resp_data !== r[31:0]
                || a_resp_id !== a_req_id)
                $display("FAIL l0_rand%0d: st %0d d %0d r %b want st %0d d %0d r %b",
                         i, a_resp_status, a_resp_data, a_req_ready,
                         r[33:32], r[31:0], i[0]);
            else n_pass++;
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        #1;
        n_checks++;
        if (a_resp_valid !== 1'b0)
            $display("FAIL l0_idle: resp_valid %b want 0", a_resp_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] av [3];
        logic [63:0] bv [3];
        int          ev [3];
        logic        exp_v;
        av = '{64'h0, 64'h5555_5555_5555_5555, 64'hF0};
        bv = '{64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hF0};
        ev = '{64, 0, 64};
        for (int cyc = 0; cyc < 6; cyc++) begin
            b_resp_ready = 1'b1;
            b_req_func   = 10'd0;
            if (cyc < 3) begin
                b_req_valid = 1'b1; b_req_id = 6'(cyc + 1);
                b_req_data0 = av[cyc]; b_req_data1 = bv[cyc];
            end else begin
                b_req_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 3) begin
                n_checks++;
                if (b_req_ready !== 1'b1)
                    $display("FAIL b2b_ready%0d: got %b want 1", cyc, b_req_ready);
                else n_pass++;
            end
            exp_v = (cyc >= 2 && cyc <= 4);
            n_checks++;
            if (b_resp_valid !== exp_v)
                $display("FAIL b2b_valid%0d: got %b want %b", cyc, b_resp_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if (b_resp_id !== 6'(cyc - 1) || b_resp_status !== 2'd0
                    || b_resp_data !== 64'(ev[cyc-2]))
                    $display("FAIL b2b_resp%0d: id %0d st %0d d %0d want id %0d d %0d",
                             cyc, b_resp_id, b_resp_status, b_resp_data,
                             cyc - 1, ev[cyc-2]);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic acc;
        int   k;
        k = 0;
        c_saw_stall = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            c_cycle(k < 8, 6'(20 + k), 10'd0, $urandom, $urandom,
                    !(cyc >= 2 && cyc < 7), acc);
            if (acc) k++;
        end
        n_checks++;
        if (!c_saw_stall || k != 8)
            $display("FAIL backpressure: stall seen %b sent %0d want 1 8", c_saw_stall, k);
        else n_pass++;
        c_drain();
    endtask

    task automatic test_unsupported;
        logic acc;
        c_cycle(1'b1, 6'd33, 10'd7, 32'h1234, $urandom, 1'b1, acc);
        c_cycle(1'b1, 6'd34, 10'd0, 32'h0F0F_0F0F, 32'h0F0F_FFFF, 1'b1, acc);
        c_drain();
    endtask

    task automatic test_popcnt;
        logic acc;
        logic [33:0] r;
        r = ref_c(10'd1, 32'h8000_0001, 32'hDEAD_BEEF);
        n_checks++;
`ifdef BNN_L2_CXU_POPCNT_FUNC_EN
        if (r !== {2'd0, 32'd2})
`else
        if (r !== {2'd1, 32'd0})
`endif
            $display("FAIL popcnt_model: got %h", r);
        else n_pass++;
        c_cycle(1'b1, 6'd40, 10'd1, 32'h8000_0001, 32'hDEAD_BEEF, 1'b1, acc);
        c_drain();
    endtask

    task automatic test_random_stream;
        logic acc;
        logic [9:0] f;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0, 1: f = 10'd0;
                2: f = 10'd1;
                3: f = 10'd7;
                default: f = 10'($urandom_range(2, 1023));
            endcase
            c_cycle($urandom_range(0, 3) != 0, 6'($urandom), f,
                    $urandom, $urandom, $urandom_range(0, 3) != 0, acc);
        end
        c_drain();
    endtask

    task automatic test_reset_inflight;
        logic acc;
        c_cycle(1'b1, 6'd10, 10'd0, $urandom, $urandom, 1'b1, acc);
        c_cycle(1'b1, 6'd11, 10'd0, $urandom, $urandom, 1'b1, acc);
        c_req_valid = 1'b0;
        #1;
        n_checks++;
        if (c_resp_valid !== 1'b1)
            $display("FAIL rst_pre: resp_valid %b want 1", c_resp_valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (c_resp_valid !== 1'b0 || c_resp_data !== 32'd0 || c_resp_id !== 6'd0
            || c_resp_status !== 2'd0 || c_req_ready !== 1'b1)
            $display("FAIL rst_async: v %b d %0d id %0d st %0d r %b want 0 0 0 0 1",
                     c_resp_valid, c_resp_data, c_resp_id, c_resp_status, c_req_ready);
        else n_pass++;
        q_id.delete(); q_st.delete(); q_dat.delete(); q_age.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        repeat (4) c_cycle(1'b0, 6'd0, 10'd0, 32'd0, 32'd0, 1'b1, acc);
        c_cycle(1'b1, 6'd5, 10'd0, 32'd0, 32'd0, 1'b1, acc);
        n_checks++;
        if (!acc || q_dat[0] !== 32'd32)
            $display("FAIL rst_new: accepted %b model data want 32", acc);
        else n_pass++;
        c_drain();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        a_req_valid = 1'b0; a_req_id = '0; a_req_func = '0;
        a_req_data0 = '0; a_req_data1 = '0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_id = '0; b_req_func = '0;
        b_req_data0 = '0; b_req_data1 = '0; b_resp_ready = 1'b1;
        c_req_valid = 1'b0; c_req_id = '0; c_req_func = '0;
        c_req_data0 = '0; c_req_data1 = '0; c_resp_ready = 1'b1;
        c_saw_stall = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        test_l0_dot();
        test_back_to_back();
        test_backpressure();
        test_unsupported();
        test_popcnt();
        test_random_stream();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
